memory_writeback_stage: RTL and testbench

MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

---
 rtl/memory_writeback_stage.sv | 207 ++++++++++++++++++++
 tb/tb_memory_writeback_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_stage.sv
// memory_writeback_stage: MEM/WB stage of a simple in-order core.
// Executes one load/store at a time on a request/ack data bus, formats store
// data and load results, reports misaligned accesses and bus timeouts, and
// returns register writebacks to EX.
module memory_writeback_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_y,
  input  logic [31:0] ex_rrd2,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_mem_op,
  input  logic [2:0]  ex_size,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        regwe,
  output logic [4:0]  regwa,
  output logic [31:0] regwd,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int              CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LIMIT = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [2:0]    size_q, size_d;
  logic          regwe_q, regwe_d;
  logic [4:0]    regwa_q, regwa_d;
  logic [31:0]   regwd_q, regwd_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic          is_mem;
  logic [CW-1:0] cnt_inc;

  // Byte sizes are 000/100, halfword sizes 001/101, everything else is a word.
  function automatic logic access_misaligned(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000, 3'b100: access_misaligned = 1'b0;
      3'b001, 3'b101: access_misaligned = a[0];
      default:        access_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000, 3'b100: store_be = 4'b0001 << a;
      3'b001, 3'b101: store_be = a[1] ? 4'b1100 : 4'b0011;
      default:        store_be = 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate the datum so every enabled lane carries it.
  function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      3'b000, 3'b100: store_wdata = {4{d[7:0]}};
      3'b001, 3'b101: store_wdata = {2{d[15:0]}};
      default:        store_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = rdata;
    endcase
  endfunction

  assign is_mem  = (ex_mem_op == 2'b01) || (ex_mem_op == 2'b10);
  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state: accept from EX in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rd_d    = rd_q;
    size_d  = size_q;
    regwe_d = 1'b0;
    regwa_d = regwa_q;
    regwd_d = regwd_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            regwe_d = (ex_rd != 5'd0);
            regwa_d = ex_rd;
            regwd_d = ex_alu_y;
          end else if (access_misaligned(ex_size, ex_alu_y[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = ex_alu_y;
            rd_d    = ex_rd;
            size_d  = ex_size;
            we_d    = (ex_mem_op == 2'b10);
            be_d    = (ex_mem_op == 2'b10) ? store_be(ex_size, ex_alu_y[1:0]) : 4'b1111;
            wdata_d = (ex_mem_op == 2'b10) ? store_wdata(ex_size, ex_rrd2) : 32'd0;
          end
        end
      end
      default: begin
        // An ack in the cycle the limit is reached still completes the access.
        if (dmem_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            regwe_d = (rd_q != 5'd0);
            regwa_d = rd_q;
            regwd_d = load_extract(size_q, addr_q[1:0], dmem_rdata);
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = IDLE;
          cnt_d   = '0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      size_q  <= '0;
      regwe_q <= 1'b0;
      regwa_q <= '0;
      regwd_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      regwe_q <= regwe_d;
      regwa_q <= regwa_d;
      regwd_q <= regwd_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  // Bus outputs are gated by ACCESS so they read zero whenever idle or in reset.
  always_comb begin
    dmem_req   = (state_q == ACCESS);
    stall      = (state_q == ACCESS);
    dmem_we    = dmem_req & we_q;
    dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    dmem_wdata = dmem_req ? wdata_q : 32'd0;
    dmem_be    = dmem_req ? be_q : 4'd0;
    regwe      = regwe_q;
    regwa      = regwa_q;
    regwd      = regwd_q;
    misaligned = mis_q;
    bus_err    = berr_q;
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Scoreboard bench for memory_writeback_stage: a driver issues instructions and
// pushes expected bus requests and retire events; a monitor pops and compares.
module tb_memory_writeback_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_y, ex_rrd2;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_size;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, regwe, misaligned, bus_err;
  logic [4:0]  regwa;
  logic [31:0] regwd;

  always #5 clk = ~clk;

  memory_writeback_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_y(ex_alu_y),
    .ex_rrd2(ex_rrd2), .ex_rd(ex_rd), .ex_mem_op(ex_mem_op), .ex_size(ex_size),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .regwe(regwe), .regwa(regwa),
    .regwd(regwd), .misaligned(misaligned), .bus_err(bus_err)
  );

  typedef struct { int kind; logic [4:0] rd; logic [31:0] val; } ev_t;   // 0 wb, 1 mis, 2 bus_err
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } rq_t;
  ev_t ev_q[$];
  rq_t rq_q[$];

  int checks = 0;
  int errors = 0;

  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = 32'd0;
  int          force_lat = -1;
  bit          ack_en = 1'b1;

  int          last_req_len = 0;
  logic [31:0] last_regwd = 32'd0;
  logic [31:0] last_req_addr = 32'd0, last_req_wdata = 32'd0;
  logic [3:0]  last_req_be = 4'd0;
  logic        last_req_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_fixed) return fixed_rdata;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Reference model. mode: 0 normal, 1 abandoned by reset, 2 bus timeout.
  task automatic model(input logic [1:0] op, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input int mode);
    int width, off, bmask;
    bit sgn;
    ev_t e;
    rq_t r;
    logic [31:0] v;
    if (op != 2'd1 && op != 2'd2) begin
      if (rd != 0) begin e.kind = 0; e.rd = rd; e.val = addr; ev_q.push_back(e); end
      return;
    end
    width = (size == 3'd0 || size == 3'd4) ? 1 : (size == 3'd1 || size == 3'd5) ? 2 : 4;
    sgn   = (size == 3'd0 || size == 3'd1);
    off   = int'(addr % 4);
    if ((addr % width) != 0) begin
      e.kind = 1; e.rd = 0; e.val = 0; ev_q.push_back(e);
      return;
    end
    bmask  = ((1 << width) - 1) << off;
    r.we   = (op == 2'd2);
    r.addr = addr - (addr % 4);
    r.be   = (op == 2'd2) ? bmask[3:0] : 4'hF;
    if (op == 2'd2)
      r.wdata = (width == 1) ? data[7:0] * 32'h01010101 :
                (width == 2) ? data[15:0] * 32'h00010001 : data;
    else
      r.wdata = 32'd0;
    rq_q.push_back(r);
    if (mode == 1) return;
    if (mode == 2) begin e.kind = 2; e.rd = 0; e.val = 0; ev_q.push_back(e); return; end
    if (op == 2'd1 && rd != 0) begin
      v = mem_word(r.addr) >> (8 * off);
      if (width == 1) begin v = v & 32'hFF;   if (sgn && v[7])  v = v | 32'hFFFFFF00; end
      if (width == 2) begin v = v & 32'hFFFF; if (sgn && v[15]) v = v | 32'hFFFF0000; end
      e.kind = 0; e.rd = rd; e.val = v; ev_q.push_back(e);
    end
  endtask

  // Called at a falling edge; holds the instruction until EX is not stalled.
  task automatic issue(input logic [1:0] op, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input int mode);
    int guard = 0;
    ex_valid = 1'b1; ex_mem_op = op; ex_size = size; ex_alu_y = addr; ex_rrd2 = data; ex_rd = rd;
    while (stall && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("issue_wait_expired", 32'd1, 32'd0);
    model(op, size, addr, data, rd, mode);
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    ex_valid = 1'b0;
    @(negedge clk);
    while (stall && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("idle_wait_expired", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // Memory responder with random latency and spurious acks while idle.
  int wcnt = 0, lat = 0;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!ack_en) dmem_ack = 1'b0;
      else begin
        if (wcnt == 0) lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        if (wcnt == lat) begin
          dmem_ack = 1'b1; dmem_rdata = mem_word(dmem_addr); wcnt = 0;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom; wcnt++;
        end
      end
    end else begin
      wcnt = 0;
      dmem_ack = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  bit  prev_req = 1'b0;
  int  req_len = 0;
  ev_t me;
  rq_t mr;
  always @(negedge clk) begin
    if (regwe) begin
      last_regwd = regwd;
      if (ev_q.size() == 0) chk("unexpected_regwe", 32'd1, 32'd0);
      else begin
        me = ev_q.pop_front();
        chk("wb_kind", 32'(me.kind), 32'd0);
        chk("wb_regwa", 32'(regwa), 32'(me.rd));
        chk("wb_regwd", regwd, me.val);
      end
    end
    if (misaligned) begin
      if (ev_q.size() == 0) chk("unexpected_misaligned", 32'd1, 32'd0);
      else begin me = ev_q.pop_front(); chk("mis_kind", 32'(me.kind), 32'd1); end
    end
    if (bus_err) begin
      if (ev_q.size() == 0) chk("unexpected_bus_err", 32'd1, 32'd0);
      else begin me = ev_q.pop_front(); chk("berr_kind", 32'(me.kind), 32'd2); end
    end
    if (dmem_req) begin
      req_len++;
      if (!prev_req) begin
        last_req_addr = dmem_addr; last_req_wdata = dmem_wdata;
        last_req_be = dmem_be; last_req_we = dmem_we;
      end
      if (rq_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        mr = rq_q[0];
        chk("req_we", 32'(dmem_we), 32'(mr.we));
        chk("req_addr", dmem_addr, mr.addr);
        chk("req_be", 32'(dmem_be), 32'(mr.be));
        if (mr.we) chk("req_wdata", dmem_wdata, mr.wdata);
      end
    end else if (prev_req) begin
      last_req_len = req_len;
      req_len = 0;
      if (rq_q.size() > 0) void'(rq_q.pop_front());
    end
    prev_req = dmem_req;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  logic [2:0] sz_tab [8];
  initial begin
    logic [1:0]  op;
    logic [2:0]  sz;
    logic [31:0] ad;
    int guard;
    sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b0; ex_valid = 1'b0; ex_alu_y = '0; ex_rrd2 = '0; ex_rd = '0;
    ex_mem_op = '0; ex_size = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_regwe", 32'(regwe), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_regwd", regwd, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ALU op to rd 5
    issue(2'd0, 3'd2, 32'h1234, 32'd0, 5'd5, 0);
    chk("alu_regwe", 32'(regwe), 32'd1);
    chk("alu_regwa", 32'(regwa), 32'd5);
    chk("alu_regwd", regwd, 32'h1234);
    chk("alu_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("alu_regwe_once", 32'(regwe), 32'd0);

    // LB / LBU at 0x103 with ack in the third ACCESS cycle
    use_fixed = 1'b1; fixed_rdata = 32'h80FF_FF00; force_lat = 2;
    issue(2'd1, 3'd0, 32'h103, 32'd0, 5'd7, 0);
    wait_idle();
    chk("lb_stall_cycles", 32'(last_req_len), 32'd3);
    chk("lb_value", last_regwd, 32'hFFFFFF80);
    issue(2'd1, 3'd4, 32'h103, 32'd0, 5'd8, 0);
    wait_idle();
    chk("lbu_value", last_regwd, 32'h00000080);
    use_fixed = 1'b0; force_lat = -1;

    // SH at 0x202
    issue(2'd2, 3'd1, 32'h202, 32'h0000ABCD, 5'd9, 0);
    wait_idle();
    chk("sh_addr", last_req_addr, 32'h200);
    chk("sh_be", 32'(last_req_be), 32'hC);
    chk("sh_wdata", last_req_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(last_req_we), 32'd1);

    // Misaligned LW
    issue(2'd1, 3'd2, 32'h101, 32'd0, 5'd10, 0);
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_no_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("mis_one_cycle", 32'(misaligned), 32'd0);
    chk("mis_no_req2", 32'(dmem_req), 32'd0);

    // Timeout, then ack exactly on the limit cycle
    ack_en = 1'b0;
    issue(2'd1, 3'd2, 32'h300, 32'd0, 5'd11, 2);
    wait_idle();
    chk("to_req_cycles", 32'(last_req_len), 32'(TO));
    ack_en = 1'b1; force_lat = TO - 1;
    issue(2'd1, 3'd2, 32'h304, 32'd0, 5'd12, 0);
    wait_idle();
    chk("ack_at_limit_cycles", 32'(last_req_len), 32'(TO));
    force_lat = -1;

    // Randomized traffic, back-to-back with occasional gaps
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      sz = sz_tab[$urandom_range(0, 7)];
      ad = $urandom;
      issue(op, sz, ad, $urandom, 5'($urandom_range(0, 31)), 0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    guard = 0;
    while ((ev_q.size() != 0 || rq_q.size() != 0 || stall) && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("random_drain_ev", 32'(ev_q.size()), 32'd0);
    chk("random_drain_rq", 32'(rq_q.size()), 32'd0);

    // Reset in the middle of an access
    ack_en = 1'b0;
    issue(2'd1, 3'd2, 32'h400, 32'd0, 5'd13, 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    ack_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    issue(2'd0, 3'd2, 32'h55, 32'd0, 5'd0, 0);
    chk("rd0_regwe", 32'(regwe), 32'd0);
    repeat (3) @(negedge clk);
    chk("final_ev_empty", 32'(ev_q.size()), 32'd0);
    chk("final_rq_empty", 32'(rq_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
